// File: rtl/vga_timing_gen_if.sv
// Pixel request / colour return and VGA connector bundle for vga_timing_gen.
// The generator drives through master; a renderer or monitor attaches through slave.
interface vga_timing_gen_if #(
  parameter int COORD_W = 10,
  parameter int C_W     = 8
);
  logic [C_W-1:0]     color_in;
  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;
  logic               next_valid;
  logic               hsync;
  logic               vsync;
  logic               blank_n;
  logic               sync_n;
  logic [7:0]         red;
  logic [7:0]         green;
  logic [7:0]         blue;
  logic               frame_start;
  logic               line_end;

  modport master (
    input  color_in,
    output next_x, next_y, next_valid,
    output hsync, vsync, blank_n, sync_n, red, green, blue,
    output frame_start, line_end
  );

  modport slave (
    output color_in,
    input  next_x, next_y, next_valid,
    input  hsync, vsync, blank_n, sync_n, red, green, blue,
    input  frame_start, line_end
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: lookahead pixel request, colour expansion to
// 8-bit DAC channels, sync/blank generation and frame/line marker pulses.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int R_BITS     = 3,
  parameter int G_BITS     = 3,
  parameter int B_BITS     = 2,
  parameter int COORD_W    = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pix_ce,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int C_W     = R_BITS + G_BITS + B_BITS;

  logic [COORD_W-1:0] hc_reg, vc_reg;
  logic [COORD_W-1:0] hc_next, vc_next;
  logic               hsync_reg, vsync_reg, blank_n_reg;
  logic [7:0]         red_reg, green_reg, blue_reg;
  logic               frame_start_reg, line_end_reg;
  logic               next_valid;
  logic               hs_active, vs_active;
  logic               h_last, v_last;

  logic [R_BITS-1:0]  r_in;
  logic [G_BITS-1:0]  g_in;
  logic [B_BITS-1:0]  b_in;
  logic [7:0]         r_exp, g_exp, b_exp;

  assign r_in = bus.color_in[C_W-1 -: R_BITS];
  assign g_in = bus.color_in[G_BITS+B_BITS-1 -: G_BITS];
  assign b_in = bus.color_in[B_BITS-1:0];

  // Replicate each channel MSB-first; the last copy is truncated at bit 0.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_expand
      assign r_exp[7-gi] = r_in[R_BITS-1-(gi % R_BITS)];
      assign g_exp[7-gi] = g_in[G_BITS-1-(gi % G_BITS)];
      assign b_exp[7-gi] = b_in[B_BITS-1-(gi % B_BITS)];
    end
  endgenerate

  // Compared as int so windows ending exactly at 2^COORD_W cannot wrap.
  assign h_last     = (int'(hc_reg) == H_TOTAL - 1);
  assign v_last     = (int'(vc_reg) == V_TOTAL - 1);
  assign next_valid = (int'(hc_reg) < H_ACTIVE) && (int'(vc_reg) < V_ACTIVE);
  assign hs_active  = (int'(hc_reg) >= H_ACTIVE + H_FRONT) &&
                      (int'(hc_reg) <  H_ACTIVE + H_FRONT + H_SYNC);
  assign vs_active  = (int'(vc_reg) >= V_ACTIVE + V_FRONT) &&
                      (int'(vc_reg) <  V_ACTIVE + V_FRONT + V_SYNC);

  always_comb begin
    hc_next = hc_reg + COORD_W'(1);
    vc_next = vc_reg;
    if (h_last) begin
      hc_next = '0;
      vc_next = v_last ? '0 : vc_reg + COORD_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hc_reg          <= '0;
      vc_reg          <= '0;
      hsync_reg       <= ~H_SYNC_POL;
      vsync_reg       <= ~V_SYNC_POL;
      blank_n_reg     <= 1'b0;
      red_reg         <= 8'h00;
      green_reg       <= 8'h00;
      blue_reg        <= 8'h00;
      frame_start_reg <= 1'b0;
      line_end_reg    <= 1'b0;
    end else begin
      // Markers last one system clock even when pix_ce is slower.
      frame_start_reg <= 1'b0;
      line_end_reg    <= 1'b0;
      if (pix_ce) begin
        hc_reg          <= hc_next;
        vc_reg          <= vc_next;
        hsync_reg       <= hs_active ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_reg       <= vs_active ? V_SYNC_POL : ~V_SYNC_POL;
        blank_n_reg     <= next_valid;
        red_reg         <= next_valid ? r_exp : 8'h00;
        green_reg       <= next_valid ? g_exp : 8'h00;
        blue_reg        <= next_valid ? b_exp : 8'h00;
        frame_start_reg <= (hc_reg == '0) && (vc_reg == '0);
        line_end_reg    <= h_last;
      end
    end
  end

  assign bus.next_x      = hc_reg;
  assign bus.next_y      = vc_reg;
  assign bus.next_valid  = next_valid;
  assign bus.hsync       = hsync_reg;
  assign bus.vsync       = vsync_reg;
  assign bus.blank_n     = blank_n_reg;
  assign bus.sync_n      = 1'b1;
  assign bus.red         = red_reg;
  assign bus.green       = green_reg;
  assign bus.blue        = blue_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.line_end    = line_end_reg;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default horizontal timing with a short frame, and a tiny
// 7x6 configuration with positive syncs and 8-bit channels.
module tb_vga_timing_gen;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_m, ce_m, rst_s, ce_s;
  int   checks   = 0;
  int   failures = 0;

  vga_timing_gen_if #(.COORD_W(10), .C_W(8))  bus_m ();
  vga_timing_gen_if #(.COORD_W(4),  .C_W(24)) bus_s ();

  // Default horizontal timing, 8-line frame: V_TOTAL=8, frame = 6400 clocks.
  vga_timing_gen #(
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_m (
    .clock(clock), .reset(rst_m), .pix_ce(ce_m), .bus(bus_m)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
    .R_BITS(8), .G_BITS(8), .B_BITS(8), .COORD_W(4)
  ) dut_s (
    .clock(clock), .reset(rst_s), .pix_ce(ce_s), .bus(bus_s)
  );

  task automatic do_reset_m();
    rst_m = 1'b0;
    ce_m  = 1'b1;
    repeat (2) @(negedge clock);
    rst_m = 1'b1;
  endtask

  task automatic test_reset();
    rst_m = 1'b0; rst_s = 1'b0; ce_m = 1'b1; ce_s = 1'b1;
    bus_m.color_in = 8'hFF;
    bus_s.color_in = 24'hFFFFFF;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus_m.hsync, bus_m.vsync, bus_m.blank_n, bus_m.sync_n, bus_m.frame_start, bus_m.line_end} !== 6'b110100) begin
      failures++;
      $display("FAIL reset_ctrl_m: got %b required 110100",
               {bus_m.hsync, bus_m.vsync, bus_m.blank_n, bus_m.sync_n, bus_m.frame_start, bus_m.line_end});
    end
    checks++;
    if ({bus_m.red, bus_m.green, bus_m.blue} !== 24'h000000) begin
      failures++;
      $display("FAIL reset_rgb_m: got %h required 000000", {bus_m.red, bus_m.green, bus_m.blue});
    end
    checks++;
    if ({bus_m.next_x, bus_m.next_y, bus_m.next_valid} !== {10'd0, 10'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_req_m: got x=%0d y=%0d v=%b required x=0 y=0 v=1",
               bus_m.next_x, bus_m.next_y, bus_m.next_valid);
    end
    checks++;
    if ({bus_s.hsync, bus_s.vsync, bus_s.blank_n, bus_s.sync_n, bus_s.frame_start, bus_s.line_end} !== 6'b000100) begin
      failures++;
      $display("FAIL reset_ctrl_s: got %b required 000100",
               {bus_s.hsync, bus_s.vsync, bus_s.blank_n, bus_s.sync_n, bus_s.frame_start, bus_s.line_end});
    end
    checks++;
    if ({bus_s.red, bus_s.green, bus_s.blue} !== 24'h000000) begin
      failures++;
      $display("FAIL reset_rgb_s: got %h required 000000", {bus_s.red, bus_s.green, bus_s.blue});
    end
    rst_m = 1'b1; rst_s = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus_m.frame_start, bus_m.line_end, bus_m.blank_n, bus_m.red, bus_m.green, bus_m.blue} !== {3'b101, 24'hFFFFFF}) begin
      failures++;
      $display("FAIL first_tick_m: got fs=%b le=%b bn=%b rgb=%h required fs=1 le=0 bn=1 rgb=ffffff",
               bus_m.frame_start, bus_m.line_end, bus_m.blank_n, {bus_m.red, bus_m.green, bus_m.blue});
    end
    checks++;
    if ({bus_m.next_x, bus_m.next_y} !== {10'd1, 10'd0}) begin
      failures++;
      $display("FAIL first_req_m: got x=%0d y=%0d required x=1 y=0", bus_m.next_x, bus_m.next_y);
    end
    checks++;
    if ({bus_s.frame_start, bus_s.next_x} !== {1'b1, 4'd1}) begin
      failures++;
      $display("FAIL first_tick_s: got fs=%b x=%0d required fs=1 x=1", bus_s.frame_start, bus_s.next_x);
    end
    $display("test_reset done");
  endtask

  task automatic test_colour();
    rst_m = 1'b0;
    ce_m  = 1'b1;
    @(negedge clock);
    bus_m.color_in = 8'b101_011_10;
    rst_m = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus_m.red, bus_m.green, bus_m.blue, bus_m.blank_n} !== {24'hB66DAA, 1'b1}) begin
      failures++;
      $display("FAIL colour_expand_a: got rgb=%h bn=%b required rgb=b66daa bn=1",
               {bus_m.red, bus_m.green, bus_m.blue}, bus_m.blank_n);
    end
    bus_m.color_in = 8'b010_100_01;
    @(negedge clock);
    checks++;
    if ({bus_m.red, bus_m.green, bus_m.blue} !== 24'h499255) begin
      failures++;
      $display("FAIL colour_expand_b: got rgb=%h required 499255", {bus_m.red, bus_m.green, bus_m.blue});
    end
    $display("test_colour done");
  endtask

  task automatic test_full_frame();
    int mis_h = 0, mis_v = 0, mis_b = 0, mis_rgb = 0, mis_fs = 0, mis_le = 0, mis_req = 0;
    int hs_low = 0, hs_first = -1, vs_low = 0, fs_cnt = 0, fs_second = -1;
    int h, v, rh, rv;
    logic blank;
    bus_m.color_in = 8'hFF;
    do_reset_m();
    for (int k = 0; k < 12800; k++) begin
      @(negedge clock);
      h = k % 800; v = (k / 800) % 8;
      rh = (k + 1) % 800; rv = ((k + 1) / 800) % 8;
      blank = (h < 640) && (v < 4);
      if (bus_m.hsync !== !((h >= 656) && (h < 752))) mis_h++;
      if (bus_m.vsync !== !((v >= 5) && (v < 7))) mis_v++;
      if (bus_m.blank_n !== blank) mis_b++;
      if ({bus_m.red, bus_m.green, bus_m.blue} !== (blank ? 24'hFFFFFF : 24'h000000)) mis_rgb++;
      if (bus_m.frame_start !== ((h == 0) && (v == 0))) mis_fs++;
      if (bus_m.line_end !== (h == 799)) mis_le++;
      if (bus_m.next_x !== 10'(rh) || bus_m.next_y !== 10'(rv) ||
          bus_m.next_valid !== ((rh < 640) && (rv < 4))) mis_req++;
      if (k < 800 && bus_m.hsync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (k < 6400 && bus_m.vsync === 1'b0) vs_low++;
      if (bus_m.frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_cnt == 2) fs_second = k;
      end
      if (k == 639) begin
        checks++;
        if ({bus_m.red, bus_m.green, bus_m.blue} !== 24'hFFFFFF) begin
          failures++;
          $display("FAIL last_active_rgb: got %h required ffffff", {bus_m.red, bus_m.green, bus_m.blue});
        end
        checks++;
        if ({bus_m.next_x, bus_m.next_valid} !== {10'd640, 1'b0}) begin
          failures++;
          $display("FAIL req_hc640: got x=%0d v=%b required x=640 v=0", bus_m.next_x, bus_m.next_valid);
        end
      end
      if (k == 640) begin
        checks++;
        if ({bus_m.red, bus_m.green, bus_m.blue, bus_m.blank_n} !== 25'd0) begin
          failures++;
          $display("FAIL hblank_out: got rgb=%h bn=%b required 000000 0",
                   {bus_m.red, bus_m.green, bus_m.blue}, bus_m.blank_n);
        end
      end
      if (k == 3199) begin
        checks++;
        if ({bus_m.next_x, bus_m.next_y, bus_m.next_valid} !== {10'd0, 10'd4, 1'b0}) begin
          failures++;
          $display("FAIL req_vc4: got x=%0d y=%0d v=%b required x=0 y=4 v=0",
                   bus_m.next_x, bus_m.next_y, bus_m.next_valid);
        end
      end
    end
    checks++; if (mis_h != 0)   begin failures++; $display("FAIL frame_hsync: mismatches=%0d required 0", mis_h); end
    checks++; if (mis_v != 0)   begin failures++; $display("FAIL frame_vsync: mismatches=%0d required 0", mis_v); end
    checks++; if (mis_b != 0)   begin failures++; $display("FAIL frame_blank: mismatches=%0d required 0", mis_b); end
    checks++; if (mis_rgb != 0) begin failures++; $display("FAIL frame_rgb: mismatches=%0d required 0", mis_rgb); end
    checks++; if (mis_fs != 0)  begin failures++; $display("FAIL frame_fs: mismatches=%0d required 0", mis_fs); end
    checks++; if (mis_le != 0)  begin failures++; $display("FAIL frame_le: mismatches=%0d required 0", mis_le); end
    checks++; if (mis_req != 0) begin failures++; $display("FAIL frame_req: mismatches=%0d required 0", mis_req); end
    checks++; if (hs_low != 96)   begin failures++; $display("FAIL hsync_width: got %0d required 96", hs_low); end
    checks++; if (hs_first != 656) begin failures++; $display("FAIL hsync_first: got %0d required 656", hs_first); end
    checks++; if (vs_low != 1600) begin failures++; $display("FAIL vsync_width: got %0d required 1600", vs_low); end
    checks++; if (fs_second != 6400) begin failures++; $display("FAIL frame_period: got %0d required 6400", fs_second); end
    $display("test_full_frame done");
  endtask

  task automatic test_ce_half();
    int mis_stable = 0, le_cnt = 0, le_first = -1, le_second = -1, fs_cnt = 0, pulse_on_idle = 0;
    logic [27:0] prev, cur;
    bus_m.color_in = 8'hFF;
    do_reset_m();
    prev = '0;
    for (int n = 0; n < 3400; n++) begin
      ce_m = (n % 2 == 0);
      @(negedge clock);
      cur = {bus_m.hsync, bus_m.vsync, bus_m.blank_n, bus_m.red, bus_m.green, bus_m.blue, 1'b0};
      if (n % 2 == 1) begin
        if (cur !== prev) mis_stable++;
        if (bus_m.frame_start !== 1'b0 || bus_m.line_end !== 1'b0) pulse_on_idle++;
      end
      if (bus_m.line_end === 1'b1) begin
        le_cnt++;
        if (le_cnt == 1) le_first = n;
        if (le_cnt == 2) le_second = n;
      end
      if (bus_m.frame_start === 1'b1) fs_cnt++;
      prev = cur;
    end
    ce_m = 1'b1;
    checks++; if (mis_stable != 0) begin failures++; $display("FAIL ce_hold: mismatches=%0d required 0", mis_stable); end
    checks++; if (pulse_on_idle != 0) begin failures++; $display("FAIL ce_pulse_width: idle pulses=%0d required 0", pulse_on_idle); end
    checks++;
    if (le_first != 1598 || le_second != 3198 || le_cnt != 2) begin
      failures++;
      $display("FAIL ce_line_period: got first=%0d second=%0d count=%0d required 1598 3198 2", le_first, le_second, le_cnt);
    end
    checks++; if (fs_cnt != 1) begin failures++; $display("FAIL ce_frame_start: got count=%0d required 1", fs_cnt); end
    $display("test_ce_half done");
  endtask

  task automatic test_small();
    int mis_h = 0, mis_v = 0, mis_rgb = 0, mis_fs = 0, mis_le = 0;
    int hs_hi = 0, vs_hi = 0, fs_second = -1, fs_cnt = 0;
    int h, v;
    logic blank;
    logic [23:0] c;
    rst_s = 1'b0; ce_s = 1'b1;
    repeat (2) @(negedge clock);
    rst_s = 1'b1;
    for (int k = 0; k < 84; k++) begin
      c = {8'(k * 37 + 1), 8'(k * 11 + 5), 8'(k * 3 + 200)};
      bus_s.color_in = c;
      @(negedge clock);
      h = k % 7; v = (k / 7) % 6;
      blank = (h < 4) && (v < 3);
      if (bus_s.hsync !== (h == 5)) mis_h++;
      if (bus_s.vsync !== (v == 4)) mis_v++;
      if ({bus_s.red, bus_s.green, bus_s.blue, bus_s.blank_n} !== (blank ? {c, 1'b1} : 25'd0)) mis_rgb++;
      if (bus_s.frame_start !== ((h == 0) && (v == 0))) mis_fs++;
      if (bus_s.line_end !== (h == 6)) mis_le++;
      if (k < 42 && bus_s.hsync === 1'b1) hs_hi++;
      if (k < 42 && bus_s.vsync === 1'b1) vs_hi++;
      if (bus_s.frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_cnt == 2) fs_second = k;
      end
    end
    checks++; if (mis_h != 0)   begin failures++; $display("FAIL small_hsync: mismatches=%0d required 0", mis_h); end
    checks++; if (mis_v != 0)   begin failures++; $display("FAIL small_vsync: mismatches=%0d required 0", mis_v); end
    checks++; if (mis_rgb != 0) begin failures++; $display("FAIL small_rgb: mismatches=%0d required 0", mis_rgb); end
    checks++; if (mis_fs != 0)  begin failures++; $display("FAIL small_fs: mismatches=%0d required 0", mis_fs); end
    checks++; if (mis_le != 0)  begin failures++; $display("FAIL small_le: mismatches=%0d required 0", mis_le); end
    checks++; if (hs_hi != 6)   begin failures++; $display("FAIL small_hsync_count: got %0d required 6", hs_hi); end
    checks++; if (vs_hi != 7)   begin failures++; $display("FAIL small_vsync_count: got %0d required 7", vs_hi); end
    checks++; if (fs_second != 42) begin failures++; $display("FAIL small_frame_period: got %0d required 42", fs_second); end
    $display("test_small done");
  endtask

  task automatic test_reset_mid();
    bus_m.color_in = 8'hFF;
    do_reset_m();
    repeat (300) @(negedge clock);
    checks++;
    if (bus_m.blank_n !== 1'b1) begin
      failures++;
      $display("FAIL mid_line_active: got bn=%b required 1", bus_m.blank_n);
    end
    @(posedge clock);
    #2;
    rst_m = 1'b0;
    #1;
    checks++;
    if ({bus_m.hsync, bus_m.vsync, bus_m.blank_n, bus_m.frame_start, bus_m.line_end,
         bus_m.red, bus_m.green, bus_m.blue, bus_m.next_x, bus_m.next_y} !== {5'b11000, 24'h0, 20'h0}) begin
      failures++;
      $display("FAIL async_reset: got ctrl=%b rgb=%h x=%0d y=%0d required ctrl=11000 rgb=000000 x=0 y=0",
               {bus_m.hsync, bus_m.vsync, bus_m.blank_n, bus_m.frame_start, bus_m.line_end},
               {bus_m.red, bus_m.green, bus_m.blue}, bus_m.next_x, bus_m.next_y);
    end
    @(negedge clock);
    rst_m = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus_m.frame_start, bus_m.next_x, bus_m.next_y} !== {1'b1, 10'd1, 10'd0}) begin
      failures++;
      $display("FAIL restart: got fs=%b x=%0d y=%0d required fs=1 x=1 y=0",
               bus_m.frame_start, bus_m.next_x, bus_m.next_y);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_colour();
    test_full_frame();
    test_ce_half();
    test_small();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA driver.
- All horizontal and vertical timings, sync polarities and per-channel input colour depths are set by parameters.
- A pixel clock-enable lets the block run from a faster system clock.
- Issues a one-tick lookahead pixel request (coordinates plus valid) to the frame-buffer/renderer, expands the returned colour to 8-bit DAC channels, and drives the VGA connector plus frame/line marker pulses.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, active level of hsync
- V_SYNC_POL, 0, active level of vsync
- R_BITS, 3, red bits in color_in (1..8)
- G_BITS, 3, green bits in color_in (1..8)
- B_BITS, 2, blue bits in color_in (1..8)
- COORD_W, 10, width of coordinate outputs; H_TOTAL and V_TOTAL must be <= 2^COORD_W

Ports:
- clock  in  1  system/pixel clock
- reset  in  1  asynchronous, active-low reset
- pix_ce  in  1  pixel tick enable; tie high for clock = pixel clock
- color_in  in  R_BITS+G_BITS+B_BITS  colour for the requested pixel, packed {R,G,B}, valid in the same cycle as the request
- next_x  out  COORD_W  requested pixel column (combinational from h counter)
- next_y  out  COORD_W  requested pixel row (combinational from v counter)
- next_valid  out  1  request lies in the active area
- hsync  out  1  to connector
- vsync  out  1  to connector
- blank_n  out  1  high during active video (to DAC BLANK)
- sync_n  out  1  constant 1 (composite sync unused)
- red  out  8  to DAC
- green  out  8  to DAC
- blue  out  8  to DAC
- frame_start  out  1  one-clock pulse when pixel (0,0) is output
- line_end  out  1  one-clock pulse when the last tick of any line is output

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL analogous.
- Counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1) advance only on a clock edge with pix_ce=1:
  - hc increments; at H_TOTAL-1 it wraps to 0 and vc increments.
  - vc wraps to 0 when hc wraps with vc=V_TOTAL-1.
- Request (combinational):
  - next_x=hc, next_y=vc.
  - next_valid=(hc<H_ACTIVE)&&(vc<V_ACTIVE).
  - Coordinates are presented even in blanking.
- Output stage: registered on the same pix_ce edge that advances the counters. Output latency is exactly one pix_ce tick after the request.
  - hsync <= H_SYNC_POL when H_ACTIVE+H_FRONT <= hc < H_ACTIVE+H_FRONT+H_SYNC, else ~H_SYNC_POL.
  - vsync <= V_SYNC_POL when V_ACTIVE+V_FRONT <= vc < V_ACTIVE+V_FRONT+V_SYNC, else ~V_SYNC_POL. Edges therefore align to line starts (hc=0).
  - blank_n <= next_valid.
  - red/green/blue <= next_valid ? expanded colour : 0.
- Colour expansion: each N-bit channel is replicated MSB-first to fill 8 bits, truncating the final copy. Examples: 3'b101 -> 8'hB6; 2'b10 -> 8'hAA; N=8 passes through. All-ones input gives 8'hFF.
- Pulses:
  - frame_start is set on a pix_ce edge with hc=0 && vc=0, and cleared on the next clock edge regardless of pix_ce. It is exactly one clock wide.
  - line_end works the same way with hc=H_TOTAL-1.
- pix_ce=0: counters, hsync, vsync, blank_n and colour outputs hold; pulses clear.
- Reset (reset=0, asynchronous, immediate):
  - hc=vc=0.
  - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL.
  - blank_n=0, red=green=blue=0, frame_start=line_end=0.
  - Reset mid-frame aborts the frame.
  - After release, the first pix_ce edge outputs pixel (0,0) and pulses frame_start.
- Non-power-of-two totals and H_FRONT/V_FRONT=0 must work. H_SYNC, V_SYNC >= 1.

Test Plan:
- Defaults, pix_ce=1:
  - hsync low exactly 96 clocks per 800-clock line, first low output after request hc=656.
  - vsync low for 1600 clocks.
  - frame_start period 420000 clocks.
- Defaults: color_in=8'b101_011_10 while next_x=0,next_y=0 -> next cycle red=8'hB6, green=8'h6D, blue=8'hAA, blank_n=1.
- color_in=8'hFF held through blanking:
  - next_valid=0 at hc=640 and at vc=480.
  - Output one tick later: rgb=0, blank_n=0.
  - At hc=639 output rgb=FF,FF,FF.
- pix_ce high every other clock: line period 1600 clocks, outputs stable across pix_ce=0 cycles, frame_start/line_end still one clock wide.
- H=4/1/1/1, V=3/1/1/1, both POL=1, R/G/B=8:
  - hsync high one tick per 7-tick line (request hc=5).
  - vsync high for line vc=4.
  - frame_start every 42 ticks.
  - color_in passes unmodified.
- Assert reset low mid-line between clock edges:
  - Outputs go to reset values immediately.
  - Release, then first pix_ce edge -> frame_start=1; next_x=1, next_y=0 afterwards.
